// File: rtl/pmod_ad1_pkg.sv
// Shared constants for the PMOD AD1 datapath (ADC interface, averager, PWM).
package pmod_ad1_pkg;

  localparam int ADC_SAMPLE_WIDTH = 12;
  localparam int ADC_NUM_CHANNELS = 2;
  localparam int MAX_LOG2_AVG     = 8;

  // Sum of 2^log2_avg unsigned samples fits exactly in this many bits.
  function automatic int acc_width(input int sample_w, input int log2_avg);
    return sample_w + log2_avg;
  endfunction

endpackage

// File: rtl/channel_accumulator.sv
// One channel of the block averager: running sum plus registered truncated mean.
module channel_accumulator
  import pmod_ad1_pkg::*;
#(
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
  parameter int LOG2_AVG     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    add,
  input  logic                    load,
  input  logic                    clear,
  input  logic                    close,
  output logic [SAMPLE_WIDTH-1:0] avg
);

  localparam int AW = acc_width(SAMPLE_WIDTH, LOG2_AVG);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  // load means the window restarts on this sample, so the old sum is ignored.
  assign sum = (load ? '0 : acc) + AW'(sample);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      acc <= '0;
      avg <= '0;
    end else if (close) begin
      acc <= '0;
      avg <= SAMPLE_WIDTH'(sum >> LOG2_AVG);
    end else if (load) begin
      acc <= AW'(sample);
    end else if (add) begin
      acc <= sum;
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/sample_averager.sv
// Decimating block-average filter: emits the truncated mean of every 2^LOG2_AVG samples per channel.
module sample_averager
  import pmod_ad1_pkg::*;
#(
  parameter int NUM_CHANNELS = ADC_NUM_CHANNELS,
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
  parameter int LOG2_AVG     = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_i,
  input  logic                                 data_valid_i,
  input  logic                                 clear_i,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] data_o,
  output logic                                 data_valid_o,
  output logic [LOG2_AVG:0]                    fill_o
);

  localparam int              CW   = LOG2_AVG + 1;
  localparam logic [CW-1:0]   LAST = CW'((1 << LOG2_AVG) - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;
  logic          close;
  logic          add;
  logic          load;
  logic          clr_only;

  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] samples;
  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] avgs;

  // A clear alongside a sample makes that sample the first of a fresh window,
  // which for LOG2_AVG=0 is also its last.
  assign cnt_eff  = clear_i ? '0 : cnt;
  assign close    = data_valid_i && (cnt_eff == LAST);
  assign load     = data_valid_i && clear_i;
  assign add      = data_valid_i && !clear_i && !close;
  assign clr_only = clear_i && !data_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt          <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= close;
      if (close)         cnt <= '0;
      else if (load)     cnt <= CW'(1);
      else if (add)      cnt <= cnt + CW'(1);
      else if (clr_only) cnt <= '0;
    end
  end

  assign fill_o  = cnt;
  assign samples = data_i;
  assign data_o  = avgs;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    channel_accumulator #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .LOG2_AVG     (LOG2_AVG)
    ) u_acc (
      .clk_i  (clk_i),
      .rst    (rst),
      .sample (samples[k]),
      .add    (add),
      .load   (load),
      .clear  (clr_only),
      .close  (close),
      .avg    (avgs[k])
    );
  end

endmodule

// File: tb/tb_sample_averager.sv
// Bench for sample_averager at LOG2_AVG = 2, 4 and 0, table-driven with an output scoreboard.
module tb_sample_averager;

  typedef logic [23:0] word_t;

  typedef struct {
    int        sel;
    bit        vld;
    bit        clr;
    logic [11:0] c0, c1;
    int        fill;
    bit        push;
    logic [11:0] e0, e1;
  } row_t;

  logic  clk;
  logic  rin [3];
  logic  vin [3];
  logic  cin [3];
  word_t din [3];
  word_t dout[3];
  logic  vout[3];
  int    fillv[3];

  logic [2:0] fill_a;
  logic [4:0] fill_b;
  logic [0:0] fill_c;

  word_t q0[$], q1[$], q2[$];
  row_t  tab[$];
  int    n_vec = 0;
  int    n_bad = 0;

  sample_averager #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(12), .LOG2_AVG(2)) u_a (
    .clk_i(clk), .rst(rin[0]), .data_i(din[0]), .data_valid_i(vin[0]), .clear_i(cin[0]),
    .data_o(dout[0]), .data_valid_o(vout[0]), .fill_o(fill_a));
  sample_averager #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(12), .LOG2_AVG(4)) u_b (
    .clk_i(clk), .rst(rin[1]), .data_i(din[1]), .data_valid_i(vin[1]), .clear_i(cin[1]),
    .data_o(dout[1]), .data_valid_o(vout[1]), .fill_o(fill_b));
  sample_averager #(.NUM_CHANNELS(2), .SAMPLE_WIDTH(12), .LOG2_AVG(0)) u_c (
    .clk_i(clk), .rst(rin[2]), .data_i(din[2]), .data_valid_i(vin[2]), .clear_i(cin[2]),
    .data_o(dout[2]), .data_valid_o(vout[2]), .fill_o(fill_c));

  assign fillv[0] = 32'(fill_a);
  assign fillv[1] = 32'(fill_b);
  assign fillv[2] = 32'(fill_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(int s, bit v, bit c, int a, int b, int f,
                              bit p = 0, int ea = 0, int eb = 0);
    row_t r;
    r.sel = s; r.vld = v; r.clr = c;
    r.c0 = 12'(a); r.c1 = 12'(b); r.fill = f;
    r.push = p; r.e0 = 12'(ea); r.e1 = 12'(eb);
    return r;
  endfunction

  task automatic chk(input string name, input int sel, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, sel, got, exp);
    end
  endtask

  task automatic push_exp(input int sel, input logic [11:0] e0, input logic [11:0] e1);
    case (sel)
      0: q0.push_back({e1, e0});
      1: q1.push_back({e1, e0});
      default: q2.push_back({e1, e0});
    endcase
  endtask

  // Drive one cycle into one DUT (others idle); returns at posedge+1.
  task automatic step(input int sel, input bit r, input bit v, input bit c,
                      input logic [11:0] a, input logic [11:0] b);
    for (int i = 0; i < 3; i++) begin
      rin[i] = 1'b0; vin[i] = 1'b0; cin[i] = 1'b0; din[i] = '0;
    end
    rin[sel] = r; vin[sel] = v; cin[sel] = c; din[sel] = {b, a};
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output pulse must match the oldest expected word.
  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      if (vout[i] === 1'b1) begin
        word_t e;
        int    sz;
        sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_pulse dut%0d: got data %h, expected no pulse", i, dout[i]);
        end else begin
          e = (i == 0) ? q0.pop_front() : (i == 1) ? q1.pop_front() : q2.pop_front();
          chk("avg_ch0", i, longint'(dout[i][11:0]),  longint'(e[11:0]));
          chk("avg_ch1", i, longint'(dout[i][23:12]), longint'(e[23:12]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rin[i] = 1'b1; vin[i] = 1'b0; cin[i] = 1'b0; din[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_data",  i, longint'(dout[i]), 0);
      chk("reset_valid", i, longint'(vout[i]), 0);
      chk("reset_fill",  i, longint'(fillv[i]), 0);
    end

    // LOG2_AVG=2: basic average, ch1 at full scale
    tab.push_back(mk(0, 1, 0, 100, 4095, 1));
    tab.push_back(mk(0, 1, 0, 200, 4095, 2));
    tab.push_back(mk(0, 1, 0, 300, 4095, 3));
    tab.push_back(mk(0, 1, 0, 400, 4095, 0, 1, 250, 4095));
    // truncation with idle gaps: (1+1+1+2)/4=1, (7+8+9+10)/4=8
    tab.push_back(mk(0, 1, 0, 1, 7, 1));
    repeat (3) tab.push_back(mk(0, 0, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 0, 1, 8, 2));
    repeat (3) tab.push_back(mk(0, 0, 0, 0, 0, 2));
    tab.push_back(mk(0, 1, 0, 1, 9, 3));
    repeat (3) tab.push_back(mk(0, 0, 0, 0, 0, 3));
    tab.push_back(mk(0, 1, 0, 2, 10, 0, 1, 1, 8));
    // standalone clear discards 10,20
    tab.push_back(mk(0, 1, 0, 10, 0, 1));
    tab.push_back(mk(0, 1, 0, 20, 0, 2));
    tab.push_back(mk(0, 0, 1, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 40, 40, 1));
    tab.push_back(mk(0, 1, 0, 40, 40, 2));
    tab.push_back(mk(0, 1, 0, 40, 40, 3));
    tab.push_back(mk(0, 1, 0, 40, 40, 0, 1, 40, 40));
    // clear coincident with a sample restarts the window on that sample
    tab.push_back(mk(0, 1, 0, 100, 0, 1));
    tab.push_back(mk(0, 1, 0, 100, 0, 2));
    tab.push_back(mk(0, 1, 1, 40, 40, 1));
    tab.push_back(mk(0, 1, 0, 40, 40, 2));
    tab.push_back(mk(0, 1, 0, 40, 40, 3));
    tab.push_back(mk(0, 1, 0, 40, 40, 0, 1, 40, 40));
    // LOG2_AVG=4: full-scale window then zero window
    for (int i = 1; i <= 16; i++)
      tab.push_back(mk(1, 1, 0, 4095, 4095, i % 16, i == 16, 4095, 4095));
    for (int i = 1; i <= 16; i++)
      tab.push_back(mk(1, 1, 0, 0, 0, i % 16, i == 16, 0, 0));
    // LOG2_AVG=0: back-to-back pass-through, then clear+sample
    tab.push_back(mk(2, 1, 0, 5, 100, 0, 1, 5, 100));
    tab.push_back(mk(2, 1, 0, 6, 200, 0, 1, 6, 200));
    tab.push_back(mk(2, 1, 0, 7, 300, 0, 1, 7, 300));
    tab.push_back(mk(2, 1, 1, 9, 9, 0, 1, 9, 9));

    foreach (tab[n]) begin
      if (tab[n].push) push_exp(tab[n].sel, tab[n].e0, tab[n].e1);
      step(tab[n].sel, 1'b0, tab[n].vld, tab[n].clr, tab[n].c0, tab[n].c1);
      chk("fill", tab[n].sel, longint'(fillv[tab[n].sel]), longint'(tab[n].fill));
    end

    // Reset mid-window (with a sample present) discards everything
    repeat (3) step(0, 1'b0, 1'b1, 1'b0, 12'd8, 12'd8);
    chk("fill_pre_rst", 0, longint'(fillv[0]), 3);
    step(0, 1'b1, 1'b1, 1'b0, 12'd8, 12'd8);
    chk("rst_data",  0, longint'(dout[0]), 0);
    chk("rst_valid", 0, longint'(vout[0]), 0);
    chk("rst_fill",  0, longint'(fillv[0]), 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push_exp(0, 12'd8, 12'd8);
      step(0, 1'b0, 1'b1, 1'b0, 12'd8, 12'd8);
    end
    chk("post_rst_fill", 0, longint'(fillv[0]), 0);

    // Clear alone keeps data_o; window restarts (else 8,8,4,4 would give 6)
    step(0, 1'b0, 1'b1, 1'b0, 12'd8, 12'd8);
    step(0, 1'b0, 1'b1, 1'b0, 12'd8, 12'd8);
    step(0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0);
    chk("clear_fill", 0, longint'(fillv[0]), 0);
    chk("clear_hold", 0, longint'(dout[0]), longint'({12'd8, 12'd8}));
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push_exp(0, 12'd4, 12'd4);
      step(0, 1'b0, 1'b1, 1'b0, 12'd4, 12'd4);
    end

    repeat (3) step(0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0);
    chk("drain_q0", 0, longint'(q0.size()), 0);
    chk("drain_q1", 1, longint'(q1.size()), 0);
    chk("drain_q2", 2, longint'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
